// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - PC owner and fetch/execute sequencer for the RV32I core.
// Optional feature: PC_MISALIGN_CHK_EN (misaligned jmp/br targets trap to trap_vec).
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        br_pc_w_op,
    input  logic [31:0] br_pc_w_val,
    input  logic        jmp_pc_w_op,
    input  logic [31:0] jmp_pc_w_val,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        fetch_ack,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    output logic [31:0] reg_pc_val,
    output logic        flush,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_FETCH_PEND = 2'd0,
        ST_FETCH      = 2'd1,
        ST_WAIT_EX    = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    // Counter is loaded with FLUSH_CYCLES-1 and counts down to zero inside FLUSH.
    localparam logic [3:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        fetch_req_q, fetch_req_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] exec_tgt;
    logic [31:0] exec_tgt_fixed;
    logic        exec_tgt_bad;

    // Jump wins over branch; the losing request is simply dropped.
    always_comb begin
        exec_tgt = jmp_pc_w_op ? jmp_pc_w_val : br_pc_w_val;
    end

`ifdef PC_MISALIGN_CHK_EN
    always_comb begin
        exec_tgt_bad   = (exec_tgt[1:0] != 2'b00);
        exec_tgt_fixed = exec_tgt_bad ? trap_vec : exec_tgt;
    end
`else
    always_comb begin
        exec_tgt_bad   = 1'b0;
        exec_tgt_fixed = {exec_tgt[31:2], 2'b00};
    end
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        misalign_d  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = pc_q;

        case (state_q)
            ST_FETCH_PEND: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A trap overrides the fetch; any ack on the same edge is discarded.
                if (trap_req) begin
                    redirect    = 1'b1;
                    redirect_pc = trap_vec;
                end else if (fetch_ack) begin
                    state_d = ST_WAIT_EX;
                end
            end
            ST_WAIT_EX: begin
                if (trap_req) begin
                    redirect    = 1'b1;
                    redirect_pc = trap_vec;
                end else if (ex_valid) begin
                    if (jmp_pc_w_op || br_pc_w_op) begin
                        redirect    = 1'b1;
                        redirect_pc = exec_tgt_fixed;
                        misalign_d  = exec_tgt_bad;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_FETCH_PEND;
            end
        endcase

        if (redirect) begin
            pc_d = redirect_pc;
            if (HAS_FLUSH) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_LAST;
            end else begin
                state_d = ST_FETCH;
            end
        end

        fetch_req_d = (state_d == ST_FETCH);
        flush_d     = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH_PEND;
            pc_q        <= RESET_PC;
            flush_cnt_q <= 4'd0;
            fetch_req_q <= 1'b0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            fetch_req_q <= fetch_req_d;
            flush_q     <= flush_d;
            misalign_q  <= misalign_d;
        end
    end

    assign fetch_req    = fetch_req_q;
    assign fetch_addr   = pc_q;
    assign reg_pc_val   = pc_q;
    assign flush        = flush_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - randomized bench for pc_seq_ctrl against a transaction-level PC model.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FC       = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        br_pc_w_op;
    logic [31:0] br_pc_w_val;
    logic        jmp_pc_w_op;
    logic [31:0] jmp_pc_w_val;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        fetch_ack;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] reg_pc_val;
    logic        flush;
    logic        misalign_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    pc_seq_ctrl #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .br_pc_w_op   (br_pc_w_op),
        .br_pc_w_val  (br_pc_w_val),
        .jmp_pc_w_op  (jmp_pc_w_op),
        .jmp_pc_w_val (jmp_pc_w_val),
        .trap_req     (trap_req),
        .trap_vec     (trap_vec),
        .fetch_ack    (fetch_ack),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .reg_pc_val   (reg_pc_val),
        .flush        (flush),
        .misalign_err (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ex_valid     = 1'b0;
        br_pc_w_op   = 1'b0;
        br_pc_w_val  = 32'h0;
        jmp_pc_w_op  = 1'b0;
        jmp_pc_w_val = 32'h0;
        trap_req     = 1'b0;
        trap_vec     = 32'h0;
        fetch_ack    = 1'b0;
    endtask

    // Where an exec-unit redirect should land, and whether it counts as misaligned.
    function automatic logic [31:0] exec_target(input logic [31:0] t, input logic [31:0] vec,
                                                output logic mis);
        mis = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
        if (t % 4 != 0) begin
            mis = 1'b1;
            return vec;
        end
        return t;
`else
        return t - (t % 4);
`endif
    endfunction

    // Called at the negedge right after a decision edge: expects fetch_req to rise
    // 'lat' samples later (counting this one) after exactly 'nfl' flush samples.
    task automatic wait_req(input int lat, input int nfl);
        int n = 1;
        int f = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (flush) f++;
            if (fetch_req) begin
                seen = 1'b1;
                break;
            end
            tick();
            n++;
        end
        check("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("req_latency", n, lat);
        check("flush_cycles", f, nfl);
        check("fetch_addr", fetch_addr, exp_pc);
        check("reg_pc_val", reg_pc_val, exp_pc);
        check("flush_off_at_req", 32'(flush), 32'd0);
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_fetch_req", 32'(fetch_req), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_pc", reg_pc_val, RESET_PC);
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        tick();
        wait_req(1, 0);
    endtask

    // One instruction: fetch handshake then one exec decision (or trap during fetch).
    task automatic run_instr(input int ack_dly, input bit tif, input bit trap, input bit ev,
                             input bit br, input logic [31:0] bt, input bit jm,
                             input logic [31:0] jt, input logic [31:0] vec, input int idle);
        logic [31:0] npc;
        logic        mis;
        bit          red;
        for (int i = 0; i < ack_dly; i++) begin
            fetch_ack = 1'b0;
            tick();
            check("req_hold", 32'(fetch_req), 32'd1);
            check("addr_hold", fetch_addr, exp_pc);
        end
        if (tif) begin
            trap_req  = 1'b1;
            trap_vec  = vec;
            fetch_ack = 1'b1;
            tick();
            clear_inputs();
            check("trap_fetch_req_drop", 32'(fetch_req), 32'd0);
            exp_pc = vec;
            wait_req(FC + 1, FC);
            return;
        end
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        check("ack_req_drop", 32'(fetch_req), 32'd0);
        for (int i = 0; i < idle; i++) begin
            br_pc_w_op   = 1'($urandom);
            br_pc_w_val  = $urandom;
            jmp_pc_w_op  = 1'($urandom);
            jmp_pc_w_val = $urandom;
            tick();
            check("idle_pc", reg_pc_val, exp_pc);
            check("idle_req", 32'(fetch_req), 32'd0);
            check("idle_flush", 32'(flush), 32'd0);
        end
        ex_valid     = ev;
        br_pc_w_op   = br;
        br_pc_w_val  = bt;
        jmp_pc_w_op  = jm;
        jmp_pc_w_val = jt;
        trap_req     = trap;
        trap_vec     = vec;
        mis          = 1'b0;
        red          = 1'b1;
        if (trap)       npc = vec;
        else if (jm)    npc = exec_target(jt, vec, mis);
        else if (br)    npc = exec_target(bt, vec, mis);
        else begin
            npc = exp_pc + 32'd4;
            red = 1'b0;
        end
        tick();
        clear_inputs();
        check("misalign_err", 32'(misalign_err), 32'(mis));
        exp_pc = npc;
        if (red) wait_req(FC + 1, FC);
        else     wait_req(1, 0);
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFC;
            1:       return r;
            default: return r & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        int kind;
        logic [31:0] vec;
        clear_inputs();
        rst_n = 1'b0;
        apply_reset();

        // Reset fetch at 0, then sequential step to 4.
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 0);
        // Long ack stall.
        run_instr(5, 0, 0, 1, 0, 0, 1, 32'h100, 32'h40, 1);
        // br and jmp together: jmp wins.
        run_instr(0, 0, 0, 1, 1, 32'h80, 1, 32'h200, 32'h40, 0);
        // Reach 0xFFFFFFFC, then wrap to 0.
        run_instr(0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h40, 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 0);
        // Trap during fetch with ack on the same edge.
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, 32'h40, 0);
        // Misaligned branch target.
        run_instr(0, 0, 0, 1, 0, 0, 1, 32'h100, 32'h40, 0);
        run_instr(1, 0, 0, 1, 1, 32'h102, 0, 0, 32'h40, 2);
        // Trap in WAIT_EX without ex_valid.
        run_instr(0, 0, 1, 0, 1, 32'h500, 1, 32'h600, 32'h80, 1);

        for (int it = 0; it < 80; it++) begin
            vec  = $urandom & 32'hFFFF_FFFC;
            kind = $urandom_range(0, 4);
            case (kind)
                0: run_instr($urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0, 1, 0, 0, 0, 0,
                             vec, $urandom_range(0, 2));
                1: run_instr($urandom_range(0, 3), 0, 0, 1, 1, rnd_tgt(), 0, 0,
                             vec, $urandom_range(0, 2));
                2: run_instr($urandom_range(0, 3), 0, 0, 1, 0, 0, 1, rnd_tgt(),
                             vec, $urandom_range(0, 2));
                3: run_instr($urandom_range(0, 3), 0, 0, 1, 1, rnd_tgt(), 1, rnd_tgt(),
                             vec, $urandom_range(0, 2));
                default: run_instr($urandom_range(0, 3), 0, 1, 1'($urandom), 1'($urandom),
                                   rnd_tgt(), 1'($urandom), rnd_tgt(), vec, $urandom_range(0, 2));
            endcase
        end

        // Asynchronous reset while flushing.
        fetch_ack = 1'b1;
        tick();
        fetch_ack    = 1'b0;
        ex_valid     = 1'b1;
        jmp_pc_w_op  = 1'b1;
        jmp_pc_w_val = 32'h300;
        tick();
        clear_inputs();
        check("flush_before_rst", 32'(flush), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_flush", 32'(flush), 32'd0);
        check("async_rst_req", 32'(fetch_req), 32'd0);
        check("async_rst_mis", 32'(misalign_err), 32'd0);
        check("async_rst_pc", reg_pc_val, RESET_PC);
        apply_reset();
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
